// File: rtl/ftdi_fifo_emulator_if.sv
// Pin/stream bundle between the FT245-style device model and its peers (controller + host side).
// The shared 8-bit data bus stays a plain inout port on the device because it is tri-stated.
interface ftdi_fifo_emulator_if #(
   parameter int ADDR_W = 4
);
   logic              in_ftdi_rd;
   logic              in_ftdi_wr;
   logic              out_ftdi_rxf;
   logic              out_ftdi_txe;
   logic [7:0]        in_host_data;
   logic              in_host_valid;
   logic              out_host_ready;
   logic [7:0]        out_host_data;
   logic              out_host_valid;
   logic              in_host_ready;
   logic [ADDR_W:0]   out_rx_level;
   logic [ADDR_W:0]   out_tx_level;
   logic [2:0]        out_err;

   modport slave (
      input  in_ftdi_rd, in_ftdi_wr, in_host_data, in_host_valid, in_host_ready,
      output out_ftdi_rxf, out_ftdi_txe, out_host_ready, out_host_data, out_host_valid,
      output out_rx_level, out_tx_level, out_err
   );

   modport master (
      output in_ftdi_rd, in_ftdi_wr, in_host_data, in_host_valid, in_host_ready,
      input  out_ftdi_rxf, out_ftdi_txe, out_host_ready, out_host_data, out_host_valid,
      input  out_rx_level, out_tx_level, out_err
   );
endinterface

// File: rtl/ftdi_fifo_emulator.sv
// FT245-style device-side peer: RX/TX byte FIFOs behind rd/wr strobes, host stream ports on the far side.
// Bus driven T_RD_TO_DATA cycles after rd is sampled; host push stalls on RX full, controller is paced by rxf/txe.
module ftdi_fifo_emulator_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic            in_clk,
   input  logic            in_rst,
   input  logic            push_vld,
   input  logic [7:0]      push_dat,
   input  logic            pop_vld,
   output logic [7:0]      head_dat,
   output logic [ADDR_W:0] level,
   output logic [ADDR_W:0] level_nxt
);
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              do_push, do_pop;

   always_comb begin
      do_push  = push_vld && (level_q != FULL);
      do_pop   = pop_vld && (level_q != '0);
      wr_ptr_d = wr_ptr_q + ADDR_W'(do_push);
      rd_ptr_d = rd_ptr_q + ADDR_W'(do_pop);
      level_d  = level_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge in_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

   assign head_dat  = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign level_nxt = level_d;
endmodule

module ftdi_fifo_emulator #(
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = 4,
   parameter int T_RD_TO_DATA   = 1,
   parameter int T_RXF_INACTIVE = 2,
   parameter int T_TXE_INACTIVE = 2
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   ftdi_fifo_emulator_if.slave  ftdi,
   inout  wire  [7:0]           io_ftdi_data
);
   localparam int CNT_W = 4;
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRIVE, R_RECOVER} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_HOLD, W_RECOVER} w_state_t;

   r_state_t         r_state_q, r_state_d;
   w_state_t         w_state_q, w_state_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic             rd_q, wr_q;
   logic             oe_q, oe_d;
   logic             rxf_q, rxf_d;
   logic             txe_q, txe_d;
   logic [2:0]       err_q, err_d;

   logic             rd_rise, wr_rise, both_hi;
   logic             rx_pop, tx_push;
   logic [7:0]       rx_head, tx_head;
   logic [ADDR_W:0]  rx_level, rx_level_nxt, tx_level, tx_level_nxt;

   ftdi_fifo_emulator_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rx_fifo (
      .in_clk    (in_clk),
      .in_rst    (in_rst),
      .push_vld  (ftdi.in_host_valid),
      .push_dat  (ftdi.in_host_data),
      .pop_vld   (rx_pop),
      .head_dat  (rx_head),
      .level     (rx_level),
      .level_nxt (rx_level_nxt)
   );

   ftdi_fifo_emulator_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_tx_fifo (
      .in_clk    (in_clk),
      .in_rst    (in_rst),
      .push_vld  (tx_push),
      .push_dat  (io_ftdi_data),
      .pop_vld   (ftdi.in_host_ready),
      .head_dat  (tx_head),
      .level     (tx_level),
      .level_nxt (tx_level_nxt)
   );

   // A cycle with both strobes high is a protocol violation: neither rise is acted on.
   always_comb begin
      rd_rise = ftdi.in_ftdi_rd & ~rd_q;
      wr_rise = ftdi.in_ftdi_wr & ~wr_q;
      both_hi = ftdi.in_ftdi_rd & ftdi.in_ftdi_wr;
      err_d   = err_q | {both_hi,
                         wr_rise & ~both_hi & ~txe_q,
                         rd_rise & ~both_hi & ~rxf_q};
   end

   always_comb begin
      r_state_d = r_state_q;
      rd_cnt_d  = rd_cnt_q;
      oe_d      = oe_q;
      rx_pop    = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            if (rd_rise && !both_hi && rxf_q) begin
               r_state_d = R_WAIT;
               rd_cnt_d  = CNT_W'(T_RD_TO_DATA - 1);
            end
         end
         R_WAIT: begin
            if (!ftdi.in_ftdi_rd) begin
               r_state_d = R_RECOVER;
               rd_cnt_d  = CNT_W'(T_RXF_INACTIVE - 1);
            end else if (rd_cnt_q == '0) begin
               r_state_d = R_DRIVE;
               oe_d      = 1'b1;
            end else begin
               rd_cnt_d  = rd_cnt_q - 1'b1;
            end
         end
         R_DRIVE: begin
            if (!ftdi.in_ftdi_rd) begin
               r_state_d = R_RECOVER;
               rd_cnt_d  = CNT_W'(T_RXF_INACTIVE - 1);
               oe_d      = 1'b0;
               rx_pop    = 1'b1;
            end
         end
         default: begin
            if (rd_cnt_q == '0) r_state_d = R_IDLE;
            else                rd_cnt_d  = rd_cnt_q - 1'b1;
         end
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      wr_cnt_d  = wr_cnt_q;
      tx_push   = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (wr_rise && !both_hi && txe_q) begin
               w_state_d = W_HOLD;
               tx_push   = 1'b1;
            end
         end
         W_HOLD: begin
            if (!ftdi.in_ftdi_wr) begin
               w_state_d = W_RECOVER;
               wr_cnt_d  = CNT_W'(T_TXE_INACTIVE - 1);
            end
         end
         default: begin
            if (wr_cnt_q == '0) w_state_d = W_IDLE;
            else                wr_cnt_d  = wr_cnt_q - 1'b1;
         end
      endcase
   end

   // Flags follow the post-edge level so the controller never sees a stale rxf/txe.
   always_comb begin
      rxf_d = (r_state_d == R_IDLE) && (rx_level_nxt != '0);
      txe_d = (w_state_d == W_IDLE) && (tx_level_nxt != FULL);
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         oe_q      <= 1'b0;
         rxf_q     <= 1'b0;
         txe_q     <= 1'b0;
         err_q     <= '0;
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_q      <= ftdi.in_ftdi_rd;
         wr_q      <= ftdi.in_ftdi_wr;
         oe_q      <= oe_d;
         rxf_q     <= rxf_d;
         txe_q     <= txe_d;
         err_q     <= err_d;
      end
   end

   assign io_ftdi_data        = oe_q ? rx_head : 8'hzz;
   assign ftdi.out_ftdi_rxf   = rxf_q;
   assign ftdi.out_ftdi_txe   = txe_q;
   assign ftdi.out_host_ready = (rx_level != FULL);
   assign ftdi.out_host_data  = tx_head;
   assign ftdi.out_host_valid = (tx_level != '0);
   assign ftdi.out_rx_level   = rx_level;
   assign ftdi.out_tx_level   = tx_level;
   assign ftdi.out_err        = err_q;
endmodule

// File: tb/tb_ftdi_fifo_emulator.sv
// Self-checking bench for ftdi_fifo_emulator: queue-based model of both FIFOs, strobe timing and sticky errors.
module tb_ftdi_fifo_emulator;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic       in_clk;
   logic       in_rst;
   logic [7:0] tb_dat;
   logic       tb_drv;
   wire  [7:0] io_ftdi_data;

   ftdi_fifo_emulator_if #(.ADDR_W(AW)) bus_if ();

   ftdi_fifo_emulator #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .in_clk       (in_clk),
      .in_rst       (in_rst),
      .ftdi         (bus_if.slave),
      .io_ftdi_data (io_ftdi_data)
   );

   assign io_ftdi_data = tb_drv ? tb_dat : 8'hzz;

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] rx_m[$];
   logic [7:0] tx_m[$];
   logic [2:0] err_m;

   task automatic step();
      @(posedge in_clk);
      #2;
   endtask

   // An undriven bus reads as Z on 4-state simulators and as 0 on 2-state ones; test bytes are never 0.
   function automatic bit bus_released();
      return (io_ftdi_data === 8'hzz) || (io_ftdi_data === 8'h00);
   endfunction

   function automatic logic [7:0] rnd_byte();
      return 8'($urandom_range(1, 255));
   endfunction

   task automatic host_push(input logic [7:0] b);
      n_cmp++;
      if (bus_if.out_host_ready !== (rx_m.size() < DEPTH)) begin
         n_fail++; $display("FAIL host_ready: got %0b want %0b", bus_if.out_host_ready, rx_m.size() < DEPTH);
      end
      bus_if.in_host_data = b; bus_if.in_host_valid = 1'b1;
      step();
      bus_if.in_host_valid = 1'b0;
      if (rx_m.size() < DEPTH) rx_m.push_back(b);
      n_cmp++;
      if (bus_if.out_rx_level !== 5'(rx_m.size())) begin
         n_fail++; $display("FAIL rx_level_push: got %0d want %0d", bus_if.out_rx_level, rx_m.size());
      end
      n_cmp++;
      if (bus_if.out_ftdi_rxf !== (rx_m.size() != 0)) begin
         n_fail++; $display("FAIL rxf_push: got %0b want %0b", bus_if.out_ftdi_rxf, rx_m.size() != 0);
      end
   endtask

   task automatic host_pop();
      n_cmp++;
      if (bus_if.out_host_valid !== (tx_m.size() != 0)) begin
         n_fail++; $display("FAIL host_valid: got %0b want %0b", bus_if.out_host_valid, tx_m.size() != 0);
      end
      if (tx_m.size() != 0) begin
         n_cmp++;
         if (bus_if.out_host_data !== tx_m[0]) begin
            n_fail++; $display("FAIL host_data: got %02h want %02h", bus_if.out_host_data, tx_m[0]);
         end
      end
      bus_if.in_host_ready = 1'b1;
      step();
      bus_if.in_host_ready = 1'b0;
      if (tx_m.size() != 0) void'(tx_m.pop_front());
      n_cmp++;
      if (bus_if.out_tx_level !== 5'(tx_m.size())) begin
         n_fail++; $display("FAIL tx_level_pop: got %0d want %0d", bus_if.out_tx_level, tx_m.size());
      end
   endtask

   task automatic do_read(input int len);
      bit ok;
      logic [7:0] exp_b;
      ok = (rx_m.size() != 0);
      exp_b = ok ? rx_m[0] : 8'h00;
      n_cmp++;
      if (bus_if.out_ftdi_rxf !== ok) begin
         n_fail++; $display("FAIL rxf_pre_rd: got %0b want %0b", bus_if.out_ftdi_rxf, ok);
      end
      bus_if.in_ftdi_rd = 1'b1;
      step();
      if (!ok) err_m[0] = 1'b1;
      n_cmp++;
      if (!bus_released()) begin
         n_fail++; $display("FAIL bus_wait: got %02h want zz", io_ftdi_data);
      end
      n_cmp++;
      if (bus_if.out_ftdi_rxf !== 1'b0) begin
         n_fail++; $display("FAIL rxf_in_rd: got %0b want 0", bus_if.out_ftdi_rxf);
      end
      for (int k = 1; k < len; k++) begin
         step();
         n_cmp++;
         if (ok && io_ftdi_data !== exp_b) begin
            n_fail++; $display("FAIL rd_bus: got %02h want %02h", io_ftdi_data, exp_b);
         end else if (!ok && !bus_released()) begin
            n_fail++; $display("FAIL rd_bus_err: got %02h want zz", io_ftdi_data);
         end
      end
      bus_if.in_ftdi_rd = 1'b0;
      step();
      if (ok) void'(rx_m.pop_front());
      n_cmp++;
      if (!bus_released()) begin
         n_fail++; $display("FAIL bus_release: got %02h want zz", io_ftdi_data);
      end
      n_cmp++;
      if (bus_if.out_rx_level !== 5'(rx_m.size())) begin
         n_fail++; $display("FAIL rx_level_rd: got %0d want %0d", bus_if.out_rx_level, rx_m.size());
      end
      n_cmp++;
      if (bus_if.out_ftdi_rxf !== 1'b0) begin
         n_fail++; $display("FAIL rxf_rec0: got %0b want 0", bus_if.out_ftdi_rxf);
      end
      step();
      n_cmp++;
      if (bus_if.out_ftdi_rxf !== 1'b0) begin
         n_fail++; $display("FAIL rxf_rec1: got %0b want 0", bus_if.out_ftdi_rxf);
      end
      step();
      n_cmp++;
      if (bus_if.out_ftdi_rxf !== (rx_m.size() != 0)) begin
         n_fail++; $display("FAIL rxf_post_rd: got %0b want %0b", bus_if.out_ftdi_rxf, rx_m.size() != 0);
      end
      n_cmp++;
      if (bus_if.out_err !== err_m) begin
         n_fail++; $display("FAIL err_rd: got %03b want %03b", bus_if.out_err, err_m);
      end
   endtask

   task automatic do_write(input logic [7:0] b, input int len);
      bit ok;
      ok = (tx_m.size() < DEPTH);
      n_cmp++;
      if (bus_if.out_ftdi_txe !== ok) begin
         n_fail++; $display("FAIL txe_pre_wr: got %0b want %0b", bus_if.out_ftdi_txe, ok);
      end
      tb_dat = b; tb_drv = 1'b1; bus_if.in_ftdi_wr = 1'b1;
      step();
      if (ok) tx_m.push_back(b); else err_m[1] = 1'b1;
      for (int k = 1; k < len; k++) begin
         step();
         n_cmp++;
         if (bus_if.out_ftdi_txe !== 1'b0) begin
            n_fail++; $display("FAIL txe_hold: got %0b want 0", bus_if.out_ftdi_txe);
         end
      end
      bus_if.in_ftdi_wr = 1'b0; tb_drv = 1'b0;
      step();
      n_cmp++;
      if (bus_if.out_ftdi_txe !== 1'b0) begin
         n_fail++; $display("FAIL txe_rec0: got %0b want 0", bus_if.out_ftdi_txe);
      end
      step();
      n_cmp++;
      if (bus_if.out_ftdi_txe !== 1'b0) begin
         n_fail++; $display("FAIL txe_rec1: got %0b want 0", bus_if.out_ftdi_txe);
      end
      step();
      n_cmp++;
      if (bus_if.out_ftdi_txe !== (tx_m.size() < DEPTH)) begin
         n_fail++; $display("FAIL txe_post_wr: got %0b want %0b", bus_if.out_ftdi_txe, tx_m.size() < DEPTH);
      end
      n_cmp++;
      if (bus_if.out_tx_level !== 5'(tx_m.size())) begin
         n_fail++; $display("FAIL tx_level_wr: got %0d want %0d", bus_if.out_tx_level, tx_m.size());
      end
      n_cmp++;
      if (tx_m.size() != 0 && bus_if.out_host_data !== tx_m[0]) begin
         n_fail++; $display("FAIL tx_head_wr: got %02h want %02h", bus_if.out_host_data, tx_m[0]);
      end
      n_cmp++;
      if (bus_if.out_err !== err_m) begin
         n_fail++; $display("FAIL err_wr: got %03b want %03b", bus_if.out_err, err_m);
      end
   endtask

   task automatic test_reset();
      in_rst = 1'b1;
      repeat (2) @(posedge in_clk);
      #2;
      n_cmp++;
      if (bus_if.out_ftdi_rxf !== 1'b0 || bus_if.out_ftdi_txe !== 1'b0) begin
         n_fail++; $display("FAIL rst_flags: got rxf=%0b txe=%0b want 0 0", bus_if.out_ftdi_rxf, bus_if.out_ftdi_txe);
      end
      n_cmp++;
      if (bus_if.out_rx_level !== 5'd0 || bus_if.out_tx_level !== 5'd0 || bus_if.out_err !== 3'd0) begin
         n_fail++; $display("FAIL rst_state: got rx=%0d tx=%0d err=%03b want 0 0 000",
                            bus_if.out_rx_level, bus_if.out_tx_level, bus_if.out_err);
      end
      n_cmp++;
      if (bus_if.out_host_valid !== 1'b0 || bus_if.out_host_ready !== 1'b1 || !bus_released()) begin
         n_fail++; $display("FAIL rst_host: got valid=%0b ready=%0b bus=%02h want 0 1 zz",
                            bus_if.out_host_valid, bus_if.out_host_ready, io_ftdi_data);
      end
      in_rst = 1'b0;
      step();
      n_cmp++;
      if (bus_if.out_ftdi_txe !== 1'b1 || bus_if.out_ftdi_rxf !== 1'b0) begin
         n_fail++; $display("FAIL rst_release: got txe=%0b rxf=%0b want 1 0", bus_if.out_ftdi_txe, bus_if.out_ftdi_rxf);
      end
   endtask

   task automatic test_read_basic();
      host_push(8'hA5);
      do_read(5);
   endtask

   task automatic test_write_basic();
      do_write(8'h3C, 5);
      host_pop();
   endtask

   task automatic test_rx_full();
      for (int i = 0; i < DEPTH + 1; i++) host_push(rnd_byte());
      for (int i = 0; i < DEPTH; i++) do_read($urandom_range(2, 4));
      do_read(3);
   endtask

   task automatic test_tx_full();
      for (int i = 0; i < DEPTH + 1; i++) do_write(rnd_byte(), $urandom_range(1, 3));
      host_pop();
      host_push(rnd_byte());
      bus_if.in_ftdi_rd = 1'b1; bus_if.in_ftdi_wr = 1'b1;
      step();
      step();
      err_m[2] = 1'b1;
      n_cmp++;
      if (bus_if.out_err !== err_m || !bus_released()) begin
         n_fail++; $display("FAIL both_hi: got err=%03b bus=%02h want %03b zz", bus_if.out_err, io_ftdi_data, err_m);
      end
      bus_if.in_ftdi_rd = 1'b0; bus_if.in_ftdi_wr = 1'b0;
      step();
      n_cmp++;
      if (bus_if.out_rx_level !== 5'(rx_m.size()) || bus_if.out_tx_level !== 5'(tx_m.size())) begin
         n_fail++; $display("FAIL both_levels: got rx=%0d tx=%0d want %0d %0d",
                            bus_if.out_rx_level, bus_if.out_tx_level, rx_m.size(), tx_m.size());
      end
      n_cmp++;
      if (bus_if.out_ftdi_rxf !== 1'b1 || bus_if.out_ftdi_txe !== 1'b1) begin
         n_fail++; $display("FAIL both_flags: got rxf=%0b txe=%0b want 1 1", bus_if.out_ftdi_rxf, bus_if.out_ftdi_txe);
      end
      do_read(2);
      while (tx_m.size() != 0) host_pop();
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      host_push(rnd_byte());
      host_push(rnd_byte());
      bus_if.in_ftdi_rd = 1'b1;
      step();
      step();
      b = rnd_byte();
      bus_if.in_ftdi_rd = 1'b0; bus_if.in_host_data = b; bus_if.in_host_valid = 1'b1;
      step();
      bus_if.in_host_valid = 1'b0;
      void'(rx_m.pop_front());
      rx_m.push_back(b);
      n_cmp++;
      if (bus_if.out_rx_level !== 5'(rx_m.size())) begin
         n_fail++; $display("FAIL rx_push_pop: got %0d want %0d", bus_if.out_rx_level, rx_m.size());
      end
      step();
      step();
      while (rx_m.size() != 0) do_read(2);
      do_write(rnd_byte(), 2);
      b = rnd_byte();
      tb_dat = b; tb_drv = 1'b1; bus_if.in_ftdi_wr = 1'b1; bus_if.in_host_ready = 1'b1;
      step();
      bus_if.in_host_ready = 1'b0;
      void'(tx_m.pop_front());
      tx_m.push_back(b);
      n_cmp++;
      if (bus_if.out_tx_level !== 5'(tx_m.size()) || bus_if.out_host_data !== b) begin
         n_fail++; $display("FAIL tx_push_pop: got lvl=%0d dat=%02h want %0d %02h",
                            bus_if.out_tx_level, bus_if.out_host_data, tx_m.size(), b);
      end
      bus_if.in_ftdi_wr = 1'b0; tb_drv = 1'b0;
      repeat (3) step();
      host_pop();
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: host_push(rnd_byte());
            1: host_pop();
            2: do_read($urandom_range(2, 6));
            default: do_write(rnd_byte(), $urandom_range(1, 6));
         endcase
      end
   endtask

   task automatic test_reset_mid_drive();
      host_push(rnd_byte());
      host_push(rnd_byte());
      do_write(rnd_byte(), 2);
      bus_if.in_ftdi_rd = 1'b1;
      step();
      step();
      n_cmp++;
      if (io_ftdi_data !== rx_m[0]) begin
         n_fail++; $display("FAIL drive_pre_rst: got %02h want %02h", io_ftdi_data, rx_m[0]);
      end
      #1 in_rst = 1'b1;
      #1;
      bus_if.in_ftdi_rd = 1'b0;
      rx_m.delete(); tx_m.delete(); err_m = 3'b000;
      n_cmp++;
      if (!bus_released()) begin
         n_fail++; $display("FAIL rst_bus: got %02h want zz", io_ftdi_data);
      end
      n_cmp++;
      if (bus_if.out_rx_level !== 5'd0 || bus_if.out_tx_level !== 5'd0 || bus_if.out_err !== 3'd0) begin
         n_fail++; $display("FAIL rst_mid: got rx=%0d tx=%0d err=%03b want 0 0 000",
                            bus_if.out_rx_level, bus_if.out_tx_level, bus_if.out_err);
      end
      step();
      in_rst = 1'b0;
      step();
      n_cmp++;
      if (bus_if.out_ftdi_txe !== 1'b1 || bus_if.out_ftdi_rxf !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_release: got txe=%0b rxf=%0b want 1 0", bus_if.out_ftdi_txe, bus_if.out_ftdi_rxf);
      end
   endtask

   initial begin
      in_rst = 1'b1;
      tb_dat = 8'h00; tb_drv = 1'b0;
      bus_if.in_ftdi_rd = 1'b0; bus_if.in_ftdi_wr = 1'b0;
      bus_if.in_host_data = 8'h00; bus_if.in_host_valid = 1'b0; bus_if.in_host_ready = 1'b0;
      err_m = 3'b000;
      test_reset();
      test_read_basic();
      test_write_basic();
      test_back_to_back();
      test_rx_full();
      test_tx_full();
      test_random();
      test_reset_mid_drive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
